// File: rtl/zoom_out_media_fsm.sv
// Block-averaging zoom-out sequencer (2x / 4x).
// Walks the reduced image in raster order, reads each BxB source block,
// accumulates it and writes the truncated mean to the output frame memory.
module zoom_out_media_fsm #(
    parameter int unsigned LARG_IN = 320,
    parameter int unsigned ALT_IN  = 240,
    parameter int unsigned PIXEL_W = 8,
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         fator_zoom,
    output logic               busy,
    output logic               done,
    output logic [9:0]         x_out,
    output logic [9:0]         y_out,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [PIXEL_W-1:0] rd_data,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [PIXEL_W-1:0] wr_data
);

    localparam int unsigned ACC_W   = PIXEL_W + 4;
    localparam int unsigned K_W     = 4;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned D_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_is4x, w_is4x_nxt;
    logic [K_W-1:0]       r_k, w_k_nxt;
    logic [D_W-1:0]       r_dcnt, w_dcnt_nxt;
    logic [RD_LAT-1:0]    r_vld, w_vld_nxt;
    logic [ACC_W-1:0]     r_acc, w_acc_nxt, w_acc_sum;
    logic [COORD_W-1:0]   r_x, w_x_nxt, r_y, w_y_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_rd_en, w_rd_en_nxt;
    logic [ADDR_W-1:0]    r_rd_addr, w_rd_addr_nxt;
    logic                 r_wr_en, w_wr_en_nxt;
    logic [ADDR_W-1:0]    r_wr_addr, w_wr_addr_nxt;
    logic [PIXEL_W-1:0]   r_wr_data, w_wr_data_nxt;

    logic [COORD_W-1:0]   w_w_out, w_h_out;
    logic [K_W-1:0]       w_k_last;
    logic                 w_x_last, w_y_last;
    logic [COORD_W-1:0]   w_x_adv, w_y_adv;
    logic                 w_fz_legal;

    // Source address of read k inside the block of output pixel (x_o, y_o)
    function automatic logic [ADDR_W-1:0] f_rd_addr(
        input logic [COORD_W-1:0] x_o,
        input logic [COORD_W-1:0] y_o,
        input logic [K_W-1:0]     k,
        input logic               is4x
    );
        logic [ADDR_W-1:0] x_src;
        logic [ADDR_W-1:0] y_src;
        if (is4x) begin
            x_src = (ADDR_W'(x_o) << 2) + ADDR_W'(k[1:0]);
            y_src = (ADDR_W'(y_o) << 2) + ADDR_W'(k[3:2]);
        end else begin
            x_src = (ADDR_W'(x_o) << 1) + ADDR_W'(k[0]);
            y_src = (ADDR_W'(y_o) << 1) + ADDR_W'(k[1]);
        end
        return ADDR_W'(y_src * ADDR_W'(LARG_IN)) + x_src;
    endfunction

    // Geometry and raster-advance helpers for the latched factor
    always_comb begin
        w_w_out    = r_is4x ? COORD_W'(LARG_IN >> 2) : COORD_W'(LARG_IN >> 1);
        w_h_out    = r_is4x ? COORD_W'(ALT_IN >> 2)  : COORD_W'(ALT_IN >> 1);
        w_k_last   = r_is4x ? K_W'(15) : K_W'(3);
        w_x_last   = (r_x == (w_w_out - COORD_W'(1)));
        w_y_last   = (r_y == (w_h_out - COORD_W'(1)));
        w_x_adv    = w_x_last ? '0 : (r_x + COORD_W'(1));
        w_y_adv    = w_x_last ? (r_y + COORD_W'(1)) : r_y;
        w_fz_legal = (fator_zoom == 2'b01) || (fator_zoom == 2'b10);
        w_acc_sum  = r_acc + (r_vld[RD_LAT-1] ? ACC_W'(rd_data) : ACC_W'(0));
    end

    // Read-valid delay line: marks the cycle each read's data returns
    always_comb begin
        w_vld_nxt    = '0;
        w_vld_nxt[0] = r_rd_en;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            w_vld_nxt[i] = r_vld[i-1];
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_is4x_nxt    = r_is4x;
        w_k_nxt       = r_k;
        w_dcnt_nxt    = r_dcnt;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_acc_nxt     = w_acc_sum;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_rd_en_nxt   = 1'b0;
        w_rd_addr_nxt = r_rd_addr;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;

        case (r_state)
            S_IDLE: begin
                if (start && w_fz_legal) begin
                    w_state_nxt   = S_READ;
                    w_is4x_nxt    = fator_zoom[1];
                    w_k_nxt       = '0;
                    w_x_nxt       = '0;
                    w_y_nxt       = '0;
                    w_acc_nxt     = '0;
                    w_busy_nxt    = 1'b1;
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = '0;
                end
            end
            S_READ: begin
                if (r_k == w_k_last) begin
                    w_state_nxt = S_DRAIN;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_k_nxt       = r_k + K_W'(1);
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = f_rd_addr(r_x, r_y, r_k + K_W'(1), r_is4x);
                end
            end
            S_DRAIN: begin
                if (r_dcnt == D_W'(RD_LAT - 1)) begin
                    w_state_nxt   = S_WRITE;
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = ADDR_W'(ADDR_W'(r_y) * ADDR_W'(w_w_out)) + ADDR_W'(r_x);
                    w_wr_data_nxt = r_is4x ? PIXEL_W'(w_acc_sum >> 4) : PIXEL_W'(w_acc_sum >> 2);
                end else begin
                    w_dcnt_nxt = r_dcnt + D_W'(1);
                end
            end
            S_WRITE: begin
                w_acc_nxt = '0;
                w_k_nxt   = '0;
                if (w_x_last && w_y_last) begin
                    w_state_nxt = S_DONE;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt   = S_READ;
                    w_x_nxt       = w_x_adv;
                    w_y_nxt       = w_y_adv;
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = f_rd_addr(w_x_adv, w_y_adv, '0, r_is4x);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is4x    <= 1'b0;
            r_k       <= '0;
            r_dcnt    <= '0;
            r_vld     <= '0;
            r_acc     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_is4x    <= w_is4x_nxt;
            r_k       <= w_k_nxt;
            r_dcnt    <= w_dcnt_nxt;
            r_vld     <= w_vld_nxt;
            r_acc     <= w_acc_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign x_out   = r_x;
    assign y_out   = r_y;
    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule

// File: tb/tb_zoom_out_media_fsm.sv
// Self-checking bench for zoom_out_media_fsm: timing/value model computed
// arithmetically from the frame geometry, compared every cycle.
module tb_zoom_out_media_fsm;

    localparam int LARG_IN = 8;
    localparam int ALT_IN  = 4;
    localparam int PIXEL_W = 8;
    localparam int ADDR_W  = 17;
    localparam int RD_LAT  = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [1:0]         fator_zoom = 2'b00;
    logic               busy, done, rd_en, wr_en;
    logic [9:0]         x_out, y_out;
    logic [ADDR_W-1:0]  rd_addr, wr_addr;
    logic [PIXEL_W-1:0] rd_data, wr_data;

    zoom_out_media_fsm #(
        .LARG_IN(LARG_IN), .ALT_IN(ALT_IN), .PIXEL_W(PIXEL_W),
        .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .fator_zoom(fator_zoom),
        .busy(busy), .done(done), .x_out(x_out), .y_out(y_out),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Input frame memory with RD_LAT-cycle read pipeline
    logic [7:0] mem [32];
    logic [7:0] pipe [RD_LAT];
    always @(posedge clk) begin
        pipe[0] <= rd_en ? mem[rd_addr[4:0]] : 8'h00;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data = pipe[RD_LAT-1];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state: frame accepted at cycle m_start with shift m_s
    bit m_active = 0;
    int m_start  = 0;
    int m_s      = 1;

    function automatic int m_rd_addr(int p, int k, int s);
        int b    = 1 << s;
        int wout = LARG_IN >> s;
        int x    = ((p % wout) << s) + (k % b);
        int y    = ((p / wout) << s) + (k / b);
        return y * LARG_IN + x;
    endfunction

    function automatic int m_avg(int p, int s);
        int sum = 0;
        for (int k = 0; k < (1 << (2 * s)); k++) sum += int'(mem[m_rd_addr(p, k, s)]);
        return sum >> (2 * s);
    endfunction

    // Logs of what the DUT actually did
    int rd_log[$];
    int wr_log_addr[$], wr_log_data[$], wr_log_x[$], wr_log_y[$];
    int done_cnt = 0;
    int done_cyc = 0;

    task automatic clear_logs();
        rd_log.delete();
        wr_log_addr.delete(); wr_log_data.delete();
        wr_log_x.delete(); wr_log_y.delete();
        done_cnt = 0;
        done_cyc = 0;
    endtask

    int t, u, p, r, n, per, wout, npix;
    bit e_busy, e_done, e_rd, e_wr;
    int e_rda, e_wa, e_wd, e_x, e_y;

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (reset) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_rd_en", rd_en, 0);
            check("rst_wr_en", wr_en, 0);
            check("rst_x_out", x_out, 0);
            check("rst_y_out", y_out, 0);
            check("rst_rd_addr", rd_addr, 0);
            check("rst_wr_addr", wr_addr, 0);
            check("rst_wr_data", wr_data, 0);
        end else begin
            e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0;
            e_rda = 0; e_wa = 0; e_wd = 0; e_x = 0; e_y = 0;
            if (m_active) begin
                t    = cyc - m_start;
                n    = 1 << (2 * m_s);
                per  = n + RD_LAT + 1;
                wout = LARG_IN >> m_s;
                npix = wout * (ALT_IN >> m_s);
                if (t >= 1 && t <= npix * per) begin
                    e_busy = 1;
                    u = t - 1;
                    p = u / per;
                    r = u % per;
                    if (r < n) begin
                        e_rd  = 1;
                        e_rda = m_rd_addr(p, r, m_s);
                    end
                    if (r == per - 1) begin
                        e_wr = 1;
                        e_wa = p;
                        e_wd = m_avg(p, m_s);
                        e_x  = p % wout;
                        e_y  = p / wout;
                    end
                end else if (t == npix * per + 1) begin
                    e_done = 1;
                end
            end
            check("busy", busy, 32'(e_busy));
            check("done", done, 32'(e_done));
            check("rd_en", rd_en, 32'(e_rd));
            check("wr_en", wr_en, 32'(e_wr));
            if (e_rd) check("rd_addr", rd_addr, e_rda);
            if (e_wr) begin
                check("wr_addr", wr_addr, e_wa);
                check("wr_data", wr_data, e_wd);
                check("x_out", x_out, e_x);
                check("y_out", y_out, e_y);
            end
            if (rd_en) rd_log.push_back(int'(rd_addr));
            if (wr_en) begin
                wr_log_addr.push_back(int'(wr_addr));
                wr_log_data.push_back(int'(wr_data));
                wr_log_x.push_back(int'(x_out));
                wr_log_y.push_back(int'(y_out));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic begin_frame(input logic [1:0] fz);
        clear_logs();
        @(posedge clk); #1;
        m_s      = (fz == 2'b10) ? 2 : 1;
        m_start  = cyc;
        m_active = 1;
        start      = 1'b1;
        fator_zoom = fz;
        @(posedge clk); #1;
        start      = 1'b0;
        fator_zoom = 2'($urandom);
    endtask

    // Run one frame to completion; optional ignored start pulse at mid_at
    task automatic run_frame(input logic [1:0] fz, input int mid_at);
        int  lper, lpix;
        bit  seen;
        begin_frame(fz);
        lper = (1 << (2 * m_s)) + RD_LAT + 1;
        lpix = (LARG_IN >> m_s) * (ALT_IN >> m_s);
        seen = 0;
        for (int i = 1; i < lpix * lper + 50 && !seen; i++) begin
            if (i == mid_at) begin
                start      = 1'b1;
                fator_zoom = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done_cnt > 0) seen = 1;
        end
        start = 1'b0;
        check("done_seen", 32'(seen), 1);
        check("write_count", wr_log_addr.size(), lpix);
        check("done_count", done_cnt, 1);
        check("frame_latency", done_cyc - m_start, lpix * lper + 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic illegal_start(input logic [1:0] fz);
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; fator_zoom = fz;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("illegal_reads", rd_log.size(), 0);
        check("illegal_done", done_cnt, 0);
    endtask

    // Reset asserted in the first DRAIN cycle of a frame
    task automatic reset_in_drain(input logic [1:0] fz);
        int nn;
        begin_frame(fz);
        nn = 1 << (2 * m_s);
        repeat (nn) @(posedge clk);
        #1;
        reset    = 1'b1;
        m_active = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_reads", rd_log.size(), nn);
        check("rst_mid_writes", wr_log_addr.size(), 0);
        check("rst_mid_done", done_cnt, 0);
    endtask

    int exp4[16] = '{0, 1, 2, 3, 8, 9, 10, 11, 16, 17, 18, 19, 24, 25, 26, 27};
    int exp2[4]  = '{0, 1, 8, 9};

    initial begin
        for (int a = 0; a < 32; a++) mem[a] = 8'(a);
        for (int i = 0; i < RD_LAT; i++) pipe[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 2x ordering and raster wrap, memory[a] = a
        run_frame(2'b01, 0);
        for (int i = 0; i < 4; i++) check("x2_read_order", rd_log[i], exp2[i]);
        check("x2_first_wr_addr", wr_log_addr[0], 0);
        check("x2_first_wr_data", wr_log_data[0], 4);
        check("x2_write_total", wr_log_addr.size(), 8);
        check("x2_latency_lit", done_cyc - m_start, 57);
        check("wrap_prev_x", wr_log_x[3], 3);
        check("wrap_x", wr_log_x[4], 0);
        check("wrap_y", wr_log_y[4], 1);
        check("wrap_addr", wr_log_addr[4], 4);

        // 4x ordering
        run_frame(2'b10, 0);
        for (int i = 0; i < 16; i++) check("x4_read_order", rd_log[i], exp4[i]);
        check("x4_wr0_data", wr_log_data[0], 13);
        check("x4_wr1_addr", wr_log_addr[1], 1);
        check("x4_wr1_data", wr_log_data[1], 17);
        check("x4_write_total", wr_log_addr.size(), 2);
        check("x4_latency_lit", done_cyc - m_start, 39);

        // Truncation
        for (int a = 0; a < 32; a++) mem[a] = 8'h00;
        mem[0] = 8'd1; mem[1] = 8'd1; mem[8] = 8'd1; mem[9] = 8'd2;
        run_frame(2'b01, 0);
        check("trunc_data", wr_log_data[0], 1);

        // Full-scale 4x block must not wrap
        for (int a = 0; a < 32; a++) mem[a] = 8'hFF;
        run_frame(2'b10, 0);
        check("sat_data0", wr_log_data[0], 255);
        check("sat_data1", wr_log_data[1], 255);

        // Illegal factors and start while busy
        illegal_start(2'b00);
        illegal_start(2'b11);
        for (int a = 0; a < 32; a++) mem[a] = 8'(a * 7 + 3);
        run_frame(2'b01, 20);
        check("busy_start_writes", wr_log_addr.size(), 8);

        // Reset mid-frame then a clean frame
        reset_in_drain(2'b01);
        run_frame(2'b01, 0);
        check("post_rst_wr_addr", wr_log_addr[0], 0);
        check("post_rst_writes", wr_log_addr.size(), 8);

        // Randomized frames
        for (int it = 0; it < 8; it++) begin
            logic [1:0] fz;
            for (int a = 0; a < 32; a++) mem[a] = 8'($urandom_range(0, 255));
            fz = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
            if ($urandom_range(0, 3) == 0) illegal_start(($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00);
            if ($urandom_range(0, 4) == 0) reset_in_drain(fz);
            run_frame(fz, ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 30)) : 0);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
